// File: rtl/demux_event_collector.sv
// Collects per-channel demux strobes into saturating counters and drains them round-robin
// as {channel, count} beats over valid/ready. Define EVC_OVF_FLAG_EN for sticky overflow flags.
module demux_event_collector #(
   parameter int NCH   = 16,
   parameter int CH_W  = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   ev_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH_W-1:0]  out_ch,
   output logic [CNT_W-1:0] out_cnt,
   output logic [NCH-1:0]   pending
`ifdef EVC_OVF_FLAG_EN
   ,
   output logic [NCH-1:0]   ovf
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [CH_W-1:0]  rr_ptr_q;
   logic [CH_W-1:0]  out_ch_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic [CH_W-1:0]  win;
   logic             found;
   logic             grant;
   logic [NCH-1:0]   clr;

   always_comb begin
      for (int i = 0; i < NCH; i++) pending[i] = (cnt_q[i] != '0);
   end

   // Search starts one past the last winner; CH_W-bit addition wraps modulo NCH.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NCH; k++) begin
         if (!found && pending[rr_ptr_q + CH_W'(k)]) begin
            found = 1'b1;
            win   = rr_ptr_q + CH_W'(k);
         end
      end
   end

   assign grant = found && (state_q == EMPTY || out_ready);

   always_comb begin
      clr = '0;
      if (grant) clr[win] = 1'b1;
   end

   // A grant restarts the count at the same-cycle strobe; saturated strobes are dropped.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         if (clr[i])
            cnt_d[i] = CNT_W'(ev_in[i]);
         else if (ev_in[i] && cnt_q[i] != CNT_MAX)
            cnt_d[i] = cnt_q[i] + 1'b1;
         else
            cnt_d[i] = cnt_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counter array is state the protocol relies on, so it is reset like any flop.
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         out_ch_q  <= '0;
         out_cnt_q <= '0;
         rr_ptr_q  <= CH_W'(NCH - 1);
      end else begin
         if (grant) begin
            state_q   <= FULL;
            out_ch_q  <= win;
            out_cnt_q <= cnt_q[win];
            rr_ptr_q  <= win;
         end else if (state_q == FULL && out_ready) begin
            state_q <= EMPTY;
         end
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_ch    = out_ch_q;
   assign out_cnt   = out_cnt_q;

`ifdef EVC_OVF_FLAG_EN
   logic [NCH-1:0] ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (clr[i])
               ovf_q[i] <= 1'b0;
            else if (ev_in[i] && cnt_q[i] == CNT_MAX)
               ovf_q[i] <= 1'b1;
         end
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_demux_event_collector.sv
// Self-checking bench for demux_event_collector: directed scenarios plus random traffic
// compared every cycle against an integer-array reference model.
module tb_demux_event_collector;

   localparam int NCH   = 16;
   localparam int CH_W  = 4;
   localparam int CNT_W = 4;
   localparam int MAX   = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [NCH-1:0]   ev_in;
   logic             out_valid;
   logic             out_ready;
   logic [CH_W-1:0]  out_ch;
   logic [CNT_W-1:0] out_cnt;
   logic [NCH-1:0]   pending;
`ifdef EVC_OVF_FLAG_EN
   logic [NCH-1:0]   ovf;
`endif

   demux_event_collector #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ev_in     (ev_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_cnt   (out_cnt),
      .pending   (pending)
`ifdef EVC_OVF_FLAG_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: event totals per channel, the outstanding beat and the last winner.
   int m_cnt [NCH];
   bit m_ovf [NCH];
   int m_ptr;
   bit m_valid;
   int m_ch;
   int m_bcnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
      end
      m_ptr   = NCH - 1;
      m_valid = 1'b0;
      m_ch    = 0;
      m_bcnt  = 0;
   endtask

   task automatic compare_model(input string tag);
      logic [NCH-1:0] exp_pend;
      exp_pend = '0;
      for (int i = 0; i < NCH; i++) exp_pend[i] = (m_cnt[i] != 0);
      check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check({tag, ".ch"},  32'(out_ch),  32'(m_ch));
         check({tag, ".cnt"}, 32'(out_cnt), 32'(m_bcnt));
      end
      check({tag, ".pending"}, 32'(pending), 32'(exp_pend));
`ifdef EVC_OVF_FLAG_EN
      begin
         logic [NCH-1:0] exp_ovf;
         for (int i = 0; i < NCH; i++) exp_ovf[i] = m_ovf[i];
         check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
      end
`endif
   endtask

   // Drive one cycle of stimulus, advance the model across the edge, then compare.
   task automatic step(input logic [NCH-1:0] ev, input bit rdy, input string tag);
      int  win;
      int  n_cnt [NCH];
      bit  load;
      ev_in     = ev;
      out_ready = rdy;
      win = -1;
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (m_ptr + k) % NCH;
         if (win < 0 && m_cnt[c] != 0) win = c;
      end
      load = (!m_valid || rdy) && (win >= 0);
      for (int i = 0; i < NCH; i++) begin
         n_cnt[i] = m_cnt[i];
         if (load && i == win) begin
            n_cnt[i] = ev[i] ? 1 : 0;
            m_ovf[i] = 1'b0;
         end else if (ev[i]) begin
            if (m_cnt[i] == MAX) m_ovf[i] = 1'b1;
            else                 n_cnt[i] = m_cnt[i] + 1;
         end
      end
      if (load) begin
         m_bcnt  = m_cnt[win];
         m_ch    = win;
         m_ptr   = win;
         m_valid = 1'b1;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      m_cnt = n_cnt;
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   // Asynchronous reset taken between clock edges; outputs must clear without an edge.
   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      ev_in     = '0;
      out_ready = 1'b0;
      #1;
      model_reset();
      check({tag, ".rst_valid"},   32'(out_valid), 32'd0);
      check({tag, ".rst_pending"}, 32'(pending),   32'd0);
      check({tag, ".rst_ch"},      32'(out_ch),    32'd0);
      check({tag, ".rst_cnt"},     32'(out_cnt),   32'd0);
`ifdef EVC_OVF_FLAG_EN
      check({tag, ".rst_ovf"},     32'(ovf),       32'd0);
`endif
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      ev_in     = '0;
      out_ready = 1'b0;
      do_reset("reset");

      // Single event on ch5: beat appears two edges after the strobe, for one cycle.
      step(16'h0020, 1'b1, "t1a");
      check("t1.no_beat_yet", 32'(out_valid), 32'd0);
      step(16'h0000, 1'b1, "t1b");
      check("t1.valid", 32'(out_valid), 32'd1);
      check("t1.ch",    32'(out_ch),    32'd5);
      check("t1.cnt",   32'(out_cnt),   32'd1);
      step(16'h0000, 1'b1, "t1c");
      check("t1.drained", 32'(out_valid), 32'd0);
      check("t1.pending", 32'(pending),   32'd0);

      // Round robin and pointer wrap: ch0 then ch15, twice.
      do_reset("t2");
      for (int r = 0; r < 2; r++) begin
         step(16'h8001, 1'b1, "t2a");
         step(16'h0000, 1'b1, "t2b");
         check("t2.first_ch",  32'(out_ch),    32'd0);
         step(16'h0000, 1'b1, "t2c");
         check("t2.second_v",  32'(out_valid), 32'd1);
         check("t2.second_ch", 32'(out_ch),    32'd15);
         step(16'h0000, 1'b1, "t2d");
         check("t2.empty",     32'(out_valid), 32'd0);
      end

      // Backpressure: beat held stable while ch3 keeps counting.
      do_reset("t3");
      for (int i = 0; i < 3; i++) step(16'h0008, 1'b0, "t3a");
      check("t3.held_ch",  32'(out_ch),     32'd3);
      check("t3.held_cnt", 32'(out_cnt),    32'd1);
      check("t3.pend3",    32'(pending[3]), 32'd1);
      step(16'h0000, 1'b1, "t3b");
      check("t3.next_cnt", 32'(out_cnt), 32'd2);
      step(16'h0000, 1'b1, "t3c");
      check("t3.empty", 32'(out_valid), 32'd0);

      // Saturation while stalled, including ready toggling on a held beat.
      do_reset("t4");
      for (int i = 0; i < 20; i++) step(16'h0008, 1'b0, "t4a");
      step(16'h0000, 1'b0, "t4b");
      check("t4.held_cnt", 32'(out_cnt), 32'd1);
`ifdef EVC_OVF_FLAG_EN
      check("t4.ovf_set", 32'(ovf[3]), 32'd1);
`endif
      step(16'h0000, 1'b1, "t4c");
      check("t4.sat_cnt", 32'(out_cnt), 32'(MAX));
`ifdef EVC_OVF_FLAG_EN
      check("t4.ovf_clr", 32'(ovf[3]), 32'd0);
`endif
      step(16'h0000, 1'b1, "t4d");

      // Grant/event collision on ch7.
      do_reset("t5");
      step(16'h0080, 1'b1, "t5a");
      step(16'h0080, 1'b1, "t5b");
      check("t5.first_cnt", 32'(out_cnt), 32'd1);
      step(16'h0000, 1'b1, "t5c");
      check("t5.second_ch",  32'(out_ch),  32'd7);
      check("t5.second_cnt", 32'(out_cnt), 32'd1);
      step(16'h0000, 1'b1, "t5d");

      // Reset while a beat is outstanding with more channels pending.
      do_reset("t6pre");
      step(16'h1248, 1'b0, "t6a");
      step(16'h0000, 1'b0, "t6b");
      check("t6.full", 32'(out_valid), 32'd1);
      do_reset("t6");
      step(16'h8001, 1'b1, "t6c");
      step(16'h0000, 1'b1, "t6d");
      check("t6.restart_ch", 32'(out_ch), 32'd0);
      step(16'h0000, 1'b1, "t6e");
      step(16'h0000, 1'b1, "t6f");

      // Randomised traffic: sparse strobes, bursts of all channels, random backpressure.
      do_reset("rnd");
      for (int n = 0; n < 600; n++) begin
         logic [NCH-1:0] ev;
         bit             rdy;
         if ($urandom_range(0, 19) == 0) ev = '1;
         else                            ev = NCH'($urandom & $urandom & $urandom);
         rdy = ($urandom_range(0, 3) != 0);
         step(ev, rdy, "rnd");
      end
      for (int n = 0; n < 40; n++) step('0, 1'b1, "rnd_drain");
      check("rnd.drained", 32'(pending), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
